// File: rtl/md_pkg.sv
// ============================================================================
// Module   : md_pkg
// Brief    : Shared encodings for the multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [1:0] MD_MULTU = 2'd0;
    localparam logic [1:0] MD_MULT  = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_DIV   = 2'd3;

    // mthi/mtlo write target and rdata read select
    localparam logic HILO_SEL_HI = 1'b1;
    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic RD_SEL_LO   = 1'b1;
    localparam logic RD_SEL_HI   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/md_if.sv
// ============================================================================
// Module   : md_if
// Brief    : EX-stage control/data bundle between decoder and md_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mdwe;
    logic             hilo;
    logic [WIDTH-1:0] wdata;
    logic             mdread;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rdata;

    modport master (
        output start, op, a, b, mdwe, hilo, wdata, mdread, cancel,
        input  busy, hi, lo, rdata
    );

    modport slave (
        input  start, op, a, b, mdwe, hilo, wdata, mdread, cancel,
        output busy, hi, lo, rdata
    );
endinterface

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
// Module   : md_arith
// Brief    : Combinational HI/LO result from latched operands and op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic [1:0]       op_i,
    output logic      [WIDTH-1:0] next_hi_o,
    output logic      [WIDTH-1:0] next_lo_o,
    output logic                  div_by_zero_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_div_b;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign w_is_div = (op_i == MD_DIVU) || (op_i == MD_DIV);
    assign w_a_neg  = w_signed & a_i[WIDTH-1];
    assign w_b_neg  = w_signed & b_i[WIDTH-1];
    assign w_b_zero = (b_i == '0);

    // Truncating the product of sign-extended operands to 2*WIDTH bits yields
    // the correct signed product, so one multiplier serves mult and multu.
    assign w_a_ext = {{WIDTH{w_a_neg}}, a_i};
    assign w_b_ext = {{WIDTH{w_b_neg}}, b_i};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide runs on magnitudes; MIN/-1 falls out as MIN rem 0.
    assign w_mag_a = w_a_neg ? (~a_i + ONE) : a_i;
    assign w_mag_b = w_b_neg ? (~b_i + ONE) : b_i;
    assign w_div_b = w_b_zero ? ONE : w_mag_b;
    assign w_q_mag = w_mag_a / w_div_b;
    assign w_r_mag = w_mag_a % w_div_b;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + ONE) : w_q_mag;
    assign w_rem   = w_a_neg ? (~w_r_mag + ONE) : w_r_mag;

    assign next_hi_o     = w_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    assign next_lo_o     = w_is_div ? w_quot : w_prod[WIDTH-1:0];
    assign div_by_zero_o = w_is_div & w_b_zero;

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Brief    : Multi-cycle mult/div unit with HI/LO, latency counter and cancel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_if.slave       bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q,   hi_d;
    logic [WIDTH-1:0] lo_q,   lo_d;
    logic [WIDTH-1:0] a_q,    a_d;
    logic [WIDTH-1:0] b_q,    b_d;
    logic [1:0]       op_q,   op_d;

    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic             w_div_by_zero;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a_i           (a_q),
        .b_i           (b_q),
        .op_i          (op_q),
        .next_hi_o     (w_next_hi),
        .next_lo_o     (w_next_lo),
        .div_by_zero_o (w_div_by_zero)
    );

    // cnt==0 is IDLE, anything else is RUN; cancel overrides everything.
    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        if (bus.cancel) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            if (bus.start) begin
                a_d   = bus.a;
                b_d   = bus.b;
                op_d  = bus.op;
                cnt_d = bus.op[1] ? DIV_CNT : MULT_CNT;
            end else if (bus.mdwe) begin
                if (bus.hilo == HILO_SEL_HI) begin
                    hi_d = bus.wdata;
                end else begin
                    lo_d = bus.wdata;
                end
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            if ((cnt_q == CNT_ONE) && !w_div_by_zero) begin
                hi_d = w_next_hi;
                lo_d = w_next_lo;
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= MD_MULTU;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.rdata = (bus.mdread == RD_SEL_LO) ? lo_q : hi_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Brief    : Scoreboard bench for md_unit with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
    import md_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t expq[$];
    int   bcnt;
    logic prev_busy;

    md_if #(.WIDTH(32)) bus ();

    md_unit #(
        .WIDTH    (32),
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int cyc);
        exp_t e;
        e.name = nm;
        e.hi   = eh;
        e.lo   = el;
        e.cyc  = cyc;
        expq.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic mtx(input logic sel, input logic [31:0] d);
        @(negedge clk);
        bus.mdwe  = 1'b1;
        bus.hilo  = sel;
        bus.wdata = d;
        @(negedge clk);
        bus.mdwe  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy still 1 after 60 cycles, required 0", nm);
        end
    endtask

    // Monitor: a falling busy marks a finished (or killed) op; compare HI/LO and duration.
    initial begin
        bcnt      = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                bcnt++;
            end else if (prev_busy) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: busy fell with no expected entry, required none");
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk({e.name, "_cycles"}, 32'(bcnt), 32'(e.cyc));
                    chk({e.name, "_hi"}, bus.hi, e.hi);
                    chk({e.name, "_lo"}, bus.lo, e.lo);
                end
                bcnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = MD_MULTU;
        bus.a      = '0;
        bus.b      = '0;
        bus.mdwe   = 1'b0;
        bus.hilo   = HILO_SEL_LO;
        bus.wdata  = '0;
        bus.mdread = RD_SEL_HI;
        bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);

        issue("mult_m1x2", MD_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        wait_idle("mult_m1x2");
        issue("multu_ffx2", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        wait_idle("multu_ffx2");
        issue("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_idle("div_m7_2");
        issue("div_min_m1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
        wait_idle("div_min_m1");
        issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle("divu_100_7");

        mtx(HILO_SEL_HI, 32'h11);
        mtx(HILO_SEL_LO, 32'h22);
        bus.mdread = RD_SEL_HI;
        #1 chk("mthi_rdata", bus.rdata, 32'h11);
        bus.mdread = RD_SEL_LO;
        #1 chk("mtlo_rdata", bus.rdata, 32'h22);
        issue("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        wait_idle("divu_by0");

        mtx(HILO_SEL_HI, 32'h1234);
        bus.mdread = RD_SEL_HI;
        #1 chk("mthi_1234_rdata", bus.rdata, 32'h1234);

        // mtlo and a second start during RUN must both be ignored
        issue("mult_3x4_busy_ign", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        @(negedge clk);
        bus.mdwe  = 1'b1;
        bus.hilo  = HILO_SEL_LO;
        bus.wdata = 32'h5678;
        @(negedge clk);
        bus.mdwe  = 1'b0;
        chk("mtlo_while_busy_lo", bus.lo, 32'h22);
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("mult_3x4_busy_ign");
        bus.mdread = RD_SEL_LO;
        #1 chk("mult_3x4_rdata_lo", bus.rdata, 32'd12);

        issue("div_cancel_c3", MD_DIV, 32'd100, 32'd7, 32'd0, 32'd12, 3);
        repeat (2) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_c3_busy", 32'(bus.busy), 32'd0);
        wait_idle("div_cancel_c3");

        issue("mult_cancel_last", MD_MULT, 32'd5, 32'd6, 32'd0, 32'd12, 5);
        repeat (4) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        wait_idle("mult_cancel_last");

        @(negedge clk);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = MD_MULT;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("cancel_same_cycle_start", 32'(bus.busy), 32'd0);

        issue("mult_reset_mid", MD_MULT, 32'd7, 32'd9, 32'd0, 32'd0, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        chk("async_reset_hi", bus.hi, 32'd0);
        chk("async_reset_lo", bus.lo, 32'd0);
        chk("async_reset_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        issue("multu_after_reset", MD_MULTU, 32'd7, 32'd9, 32'd0, 32'h3F, 5);
        wait_idle("multu_after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
